// File: rtl/my_i2c_target.sv
// my_i2c_target: I2C responder with a byte-wide register file.
// SDA is open-drain through my_sda_t; SCL is only observed, never stretched.
module my_i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h5B,
    parameter int         NUM_REGS    = 8,
    parameter int         PTR_W       = 3
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_aresetn,
    input  logic             my_scl_i,
    input  logic             my_sda_i,
    output logic             my_sda_o,
    output logic             my_sda_t,
    output logic             busy,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] dbg_rd_addr,
    output logic [7:0]       dbg_rd_data
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_PTR      = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_WR       = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD       = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic               scl_s1_q, scl_s2_q, scl_h_q;
    logic               sda_s1_q, sda_s2_q, sda_h_q;
    logic [3:0]         cnt_q, cnt_d;
    logic [6:0]         sh_q, sh_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               rw_q, rw_d;
    logic               sda_t_q, sda_t_d;
    logic               busy_q, busy_d;
    logic               wr_strobe_q;
    logic [PTR_W-1:0]   wr_addr_q;
    logic [7:0]         wr_data_q;
    logic [7:0]         regs_q [NUM_REGS];
    logic               wr_en_s;

    logic       scl_rise_s, scl_fall_s, start_s, stop_s;
    logic       last_bit_s, last_rise_s, ack_done_s, addr_hit_s;
    logic [7:0] rx_byte_s, cur_byte_s;

    assign scl_rise_s  = scl_s2_q & ~scl_h_q;
    assign scl_fall_s  = ~scl_s2_q & scl_h_q;
    assign start_s     = ~sda_s2_q & sda_h_q & scl_s2_q;
    assign stop_s      = sda_s2_q & ~sda_h_q & scl_s2_q;
    assign last_bit_s  = (cnt_q == 4'd7);
    assign last_rise_s = scl_rise_s & last_bit_s;
    assign ack_done_s  = scl_fall_s & (cnt_q == 4'd1);
    assign rx_byte_s   = {sh_q, sda_s2_q};
    assign addr_hit_s  = (rx_byte_s[7:1] == TARGET_ADDR);
    assign cur_byte_s  = regs_q[ptr_q];

    // Pin synchronizers plus history flops for edge detection
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
            {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
        end else begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= {my_scl_i, scl_s1_q, scl_s2_q};
            {sda_s1_q, sda_s2_q, sda_h_q} <= {my_sda_i, sda_s1_q, sda_s2_q};
        end
    end

    // State, datapath and register-file flops
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            sh_q        <= 7'd0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_t_q     <= sda_t_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_en_s;
            if (wr_en_s) begin
                regs_q[ptr_q] <= rx_byte_s;
                wr_addr_q     <= ptr_q;
                wr_data_q     <= rx_byte_s;
            end
        end
    end

    // Next-state logic; STOP and START override every state
    always_comb begin
        state_d = state_q;
        if (stop_s) begin
            state_d = S_IDLE;
        end else if (start_s) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR:     state_d = last_rise_s ? (addr_hit_s ? S_ADDR_ACK : S_IGNORE) : state_q;
                S_PTR:      state_d = last_rise_s ? S_PTR_ACK : state_q;
                S_WR:       state_d = last_rise_s ? S_WR_ACK : state_q;
                S_ADDR_ACK: state_d = ack_done_s ? (rw_q ? S_RD : S_PTR) : state_q;
                S_PTR_ACK:  state_d = ack_done_s ? S_WR : state_q;
                S_WR_ACK:   state_d = ack_done_s ? S_WR : state_q;
                S_RD:       state_d = (scl_fall_s && last_bit_s) ? S_RD_ACK : state_q;
                S_RD_ACK: begin
                    if (scl_rise_s && sda_s2_q) begin
                        state_d = S_IGNORE;
                    end else if (ack_done_s) begin
                        state_d = S_RD;
                    end else begin
                        state_d = state_q;
                    end
                end
                default:    state_d = state_q;
            endcase
        end
    end

    // Datapath next values: shifting, pointer, SDA drive, busy, write enable
    always_comb begin
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        sda_t_d = sda_t_q;
        busy_d  = busy_q;
        wr_en_s = 1'b0;
        if (stop_s) begin
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else if (start_s) begin
            sda_t_d = 1'b1;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WR: begin
                    if (scl_rise_s) begin
                        sh_d  = rx_byte_s[6:0];
                        cnt_d = last_bit_s ? 4'd0 : cnt_q + 4'd1;
                    end else begin
                        sh_d  = sh_q;
                    end
                    if (last_rise_s && state_q == S_ADDR) begin
                        busy_d = addr_hit_s ? 1'b1 : busy_q;
                        rw_d   = sda_s2_q;
                    end else if (last_rise_s && state_q == S_PTR) begin
                        ptr_d = rx_byte_s[PTR_W-1:0];
                    end else if (last_rise_s) begin
                        wr_en_s = 1'b1;
                        ptr_d   = ptr_q + PTR_W'(1);
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                    // First fall drives the ACK; second fall hands over to data
                    if (scl_fall_s && cnt_q == 4'd0) begin
                        sda_t_d = 1'b0;
                        cnt_d   = 4'd1;
                    end else if (ack_done_s && state_q == S_ADDR_ACK && rw_q) begin
                        sda_t_d = cur_byte_s[7];
                        sh_d    = cur_byte_s[6:0];
                        cnt_d   = 4'd0;
                    end else if (ack_done_s) begin
                        sda_t_d = 1'b1;
                        cnt_d   = 4'd0;
                    end else begin
                        sda_t_d = sda_t_q;
                    end
                end
                S_RD: begin
                    if (scl_fall_s && last_bit_s) begin
                        sda_t_d = 1'b1;
                        cnt_d   = 4'd0;
                    end else if (scl_fall_s) begin
                        sda_t_d = sh_q[6];
                        sh_d    = {sh_q[5:0], 1'b1};
                        cnt_d   = cnt_q + 4'd1;
                    end else begin
                        sda_t_d = sda_t_q;
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise_s && sda_s2_q) begin
                        busy_d = 1'b0;
                    end else if (scl_rise_s) begin
                        ptr_d = ptr_q + PTR_W'(1);
                        cnt_d = 4'd1;
                    end else if (ack_done_s) begin
                        sda_t_d = cur_byte_s[7];
                        sh_d    = cur_byte_s[6:0];
                        cnt_d   = 4'd0;
                    end else begin
                        sda_t_d = sda_t_q;
                    end
                end
                default: begin
                    sda_t_d = sda_t_q;
                end
            endcase
        end
    end

    assign my_sda_o    = 1'b0;
    assign my_sda_t    = sda_t_q;
    assign busy        = busy_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign dbg_rd_data = regs_q[dbg_rd_addr];

endmodule

// File: tb/tb_my_i2c_target.sv
// Directed bench for my_i2c_target: a bit-banged I2C master on an open-drain SDA line.
module tb_my_i2c_target;
    localparam int T = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m, sda_line;
    logic       my_sda_o, my_sda_t, busy, wr_strobe;
    logic [2:0] wr_addr, dbg_rd_addr;
    logic [7:0] wr_data, dbg_rd_data;

    int passed = 0, total = 0, failed = 0;
    int strobe_cnt = 0, drove_cnt = 0, busy_cnt = 0;
    logic [2:0] log_addr [$];
    logic [7:0] log_data [$];

    always #5 clk = ~clk;
    assign sda_line = sda_m & (my_sda_t ? 1'b1 : my_sda_o);

    my_i2c_target dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .my_scl_i       (scl_m),
        .my_sda_i       (sda_line),
        .my_sda_o       (my_sda_o),
        .my_sda_t       (my_sda_t),
        .busy           (busy),
        .wr_strobe      (wr_strobe),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .dbg_rd_addr    (dbg_rd_addr),
        .dbg_rd_data    (dbg_rd_data)
    );

    // Bus monitor: log write pulses and count cycles with SDA driven / busy high
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (my_sda_t === 1'b0) drove_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clks(T);
        sda_m = 1'b0; wait_clks(T);
        scl_m = 1'b0; wait_clks(T);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_clks(T);
        scl_m = 1'b1; wait_clks(T);
        sda_m = 1'b0; wait_clks(T);
        scl_m = 1'b0; wait_clks(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(T);
        scl_m = 1'b1; wait_clks(T);
        sda_m = 1'b1; wait_clks(T);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_clks(T);
        scl_m = 1'b1; wait_clks(T);
        scl_m = 1'b0; wait_clks(T);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clks(T);
        scl_m = 1'b1; wait_clks(T / 2);
        b = sda_line; wait_clks(T / 2);
        scl_m = 1'b0; wait_clks(T);
    endtask

    // Returns the raw ACK-slot level: 0 = ACK, 1 = NACK
    task automatic write_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(nack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic peek(input logic [2:0] idx, output logic [7:0] v);
        dbg_rd_addr = idx;
        #1;
        v = dbg_rd_data;
    endtask

    initial begin
        logic       nk;
        logic [7:0] d;
        int         base, bd, bb;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; dbg_rd_addr = 3'd0;
        wait_clks(3);
        chk("rst_sda_t", my_sda_t, 1'b1);
        chk("rst_sda_o", my_sda_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 3'd0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_reg0", dbg_rd_data, 8'h00);
        rst_n = 1'b1;
        wait_clks(5);

        // 1: register write 0xAB,0xCD at pointer 2
        base = strobe_cnt;
        i2c_start();
        write_byte(8'hB6, nk); chk("t1_addr_ack", nk, 1'b0);
        write_byte(8'h02, nk); chk("t1_ptr_ack", nk, 1'b0);
        write_byte(8'hAB, nk); chk("t1_d0_ack", nk, 1'b0);
        write_byte(8'hCD, nk); chk("t1_d1_ack", nk, 1'b0);
        chk("t1_busy_mid", busy, 1'b1);
        i2c_stop(); wait_clks(5);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_strobes", strobe_cnt - base, 2);
        chk("t1_wa0", log_addr[base], 3'd2);
        chk("t1_wd0", log_data[base], 8'hAB);
        chk("t1_wa1", log_addr[base + 1], 3'd3);
        chk("t1_wd1", log_data[base + 1], 8'hCD);
        peek(3'd2, d); chk("t1_reg2", d, 8'hAB);
        peek(3'd3, d); chk("t1_reg3", d, 8'hCD);

        // 2: pointer set, repeated start, read two bytes
        base = strobe_cnt;
        i2c_start();
        write_byte(8'hB6, nk); chk("t2_addr_ack", nk, 1'b0);
        write_byte(8'h02, nk); chk("t2_ptr_ack", nk, 1'b0);
        i2c_rstart();
        write_byte(8'hB7, nk); chk("t2_raddr_ack", nk, 1'b0);
        read_byte(d, 1'b0); chk("t2_rd0", d, 8'hAB);
        read_byte(d, 1'b1); chk("t2_rd1", d, 8'hCD);
        chk("t2_busy_nack", busy, 1'b0);
        i2c_stop(); wait_clks(5);
        chk("t2_sda_rel", my_sda_t, 1'b1);
        chk("t2_strobes", strobe_cnt - base, 0);
        peek(3'd2, d); chk("t2_reg2", d, 8'hAB);

        // 3: address mismatch is ignored completely
        base = strobe_cnt; bd = drove_cnt; bb = busy_cnt;
        i2c_start();
        write_byte(8'hB4, nk); chk("t3_addr_nack", nk, 1'b1);
        write_byte(8'h11, nk); chk("t3_data_nack", nk, 1'b1);
        i2c_stop(); wait_clks(5);
        chk("t3_no_drive", drove_cnt - bd, 0);
        chk("t3_no_busy", busy_cnt - bb, 0);
        chk("t3_strobes", strobe_cnt - base, 0);

        // 4: pointer wrap 7 -> 0, then pointer byte 0xFA selects index 2
        base = strobe_cnt;
        i2c_start();
        write_byte(8'hB6, nk);
        write_byte(8'h07, nk);
        write_byte(8'h11, nk);
        write_byte(8'h22, nk); chk("t4_d1_ack", nk, 1'b0);
        i2c_stop(); wait_clks(5);
        peek(3'd7, d); chk("t4_reg7", d, 8'h11);
        peek(3'd0, d); chk("t4_reg0", d, 8'h22);
        chk("t4_wa_wrap", log_addr[base + 1], 3'd0);
        i2c_start();
        write_byte(8'hB6, nk);
        write_byte(8'hFA, nk);
        write_byte(8'h5A, nk);
        i2c_stop(); wait_clks(5);
        peek(3'd2, d); chk("t4_reg2_fa", d, 8'h5A);
        chk("t4_wa_fa", log_addr[base + 2], 3'd2);

        // 5: zero-length write keeps the pointer (now 3)
        base = strobe_cnt;
        i2c_start();
        write_byte(8'hB6, nk); chk("t5_addr_ack", nk, 1'b0);
        chk("t5_busy_on", busy, 1'b1);
        i2c_stop(); wait_clks(5);
        chk("t5_busy_off", busy, 1'b0);
        chk("t5_strobes", strobe_cnt - base, 0);
        i2c_start();
        write_byte(8'hB7, nk);
        read_byte(d, 1'b1); chk("t5_rd_ptr", d, 8'hCD);
        i2c_stop(); wait_clks(5);

        // 6: reset while the target drives the 0 MSB of regs[0]=0x22
        i2c_start();
        write_byte(8'hB6, nk);
        write_byte(8'h00, nk);
        i2c_rstart();
        write_byte(8'hB7, nk); chk("t6_raddr_ack", nk, 1'b0);
        chk("t6_driving0", my_sda_t, 1'b0);
        rst_n = 1'b0;
        wait_clks(1);
        chk("t6_rel_next", my_sda_t, 1'b1);
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(2);
        chk("t6_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            peek(3'(i), d);
            chk($sformatf("t6_reg%0d", i), d, 8'h00);
        end
        i2c_stop(); wait_clks(5);
        i2c_start();
        write_byte(8'hB7, nk); chk("t6_addr2_ack", nk, 1'b0);
        read_byte(d, 1'b1); chk("t6_rd_zero", d, 8'h00);
        i2c_stop(); wait_clks(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
